// File: rtl/gnss_pps_pkg.sv
// Shared definitions for the GNSS PPS blocks: pps_capture register map, FSM states and
// STATUS/CTRL bit positions.
package gnss_pps_pkg;

    localparam logic [5:0] PPS_CAP_CTRL        = 6'd0;
    localparam logic [5:0] PPS_CAP_STATUS      = 6'd1;
    localparam logic [5:0] PPS_CAP_MIN_PERIOD  = 6'd2;
    localparam logic [5:0] PPS_CAP_MAX_PERIOD  = 6'd3;
    localparam logic [5:0] PPS_CAP_FIFO_DATA   = 6'd4;
    localparam logic [5:0] PPS_CAP_LAST_PERIOD = 6'd5;
    localparam logic [5:0] PPS_CAP_FREE_COUNT  = 6'd6;

    localparam int unsigned CTRL_ENABLE_BIT  = 0;
    localparam int unsigned CTRL_POLAR_BIT   = 1;
    localparam int unsigned CTRL_INT_EN_BIT  = 2;

    localparam int unsigned STAT_LOCKED_BIT  = 3;
    localparam int unsigned STAT_MISSING_BIT = 4;
    localparam int unsigned STAT_OVF_BIT     = 5;

    typedef enum logic [1:0] {
        StIdle,
        StAcquire,
        StTrack,
        StLocked
    } pps_cap_state_e;

    // STATUS only has room for a 3-bit occupancy field.
    function automatic logic [2:0] sat_cnt3(input int unsigned cnt);
        return (cnt > 7) ? 3'd7 : cnt[2:0];
    endfunction

endpackage

// File: rtl/pps_cap_fifo.sv
// Synchronous timestamp FIFO with occupancy count; pushes while full are refused unless a
// pop happens in the same cycle.
module pps_cap_fifo #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned WIDTH      = 32
) (
    input  logic                          clk,
    input  logic                          rst_b,
    input  logic                          flush,
    input  logic                          push,
    input  logic [WIDTH-1:0]              push_data,
    input  logic                          pop,
    output logic [WIDTH-1:0]              rd_data,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          full,
    output logic                          empty
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);

    logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      cnt_q;
    logic             push_ok, pop_ok;

    assign full    = (cnt_q == FULL_CNT);
    assign empty   = (cnt_q == '0);
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);
    assign rd_data = mem_q[rd_ptr_q];
    assign count   = cnt_q;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push_ok && !pop_ok)      cnt_q <= cnt_q + 1'b1;
            else if (pop_ok && !push_ok) cnt_q <= cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !flush) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/pps_capture.sv
// External PPS timestamping, period window check and lock tracking with host-readable FIFO.
// Optional glitch filter on the synchronized input: define PPS_CAP_FILTER_EN.
module pps_capture
    import gnss_pps_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned LOCK_CNT   = 3,
    parameter int unsigned FILTER_LEN = 4
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic        host_cs,
    input  logic        host_rd,
    input  logic        host_wr,
    input  logic [5:0]  host_addr,
    input  logic [31:0] host_d4wt,
    output logic [31:0] host_d4rd,
    input  logic        pps_in,
    output logic        pps_cap_irq,
    output logic        pps_locked
);

    localparam int unsigned GW = $clog2(LOCK_CNT + 1);
    localparam logic [GW-1:0] LOCK_TGT = GW'(LOCK_CNT);

    if (FILTER_LEN < 1 || LOCK_CNT < 1) begin : g_param_check
        $error("pps_capture: FILTER_LEN and LOCK_CNT must be at least 1");
    end

    logic enable_q, polar_q, int_en_q;
    logic [31:0] min_q, max_q, free_cnt_q, last_cap_q, last_period_q, since_edge_q, period;
    logic ovf_q, missing_q, ovf_set, missing_set, period_upd;
    logic [1:0] sync_q;
    logic raw_lvl, lvl, lvl_prev_q, edge_q, in_win, timeout;
    logic [GW-1:0] good_cnt_q, good_d, good_inc;
    pps_cap_state_e state_q, state_d;

    logic wr_en, status_wr, flush, push, pop;
    logic [31:0] fifo_rd_data;
    logic [$clog2(FIFO_DEPTH):0] fifo_cnt;
    logic fifo_full, fifo_empty;

    assign wr_en     = host_cs & host_wr;
    assign status_wr = wr_en & (host_addr == PPS_CAP_STATUS);
    assign flush     = wr_en & (host_addr == PPS_CAP_CTRL) & ~host_d4wt[CTRL_ENABLE_BIT];
    assign pop       = host_cs & host_rd & (host_addr == PPS_CAP_FIFO_DATA) & ~fifo_empty;
    assign push      = edge_q & enable_q & (state_q != StIdle);
    assign ovf_set   = push & fifo_full & ~pop;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            enable_q <= 1'b0;
            polar_q  <= 1'b0;
            int_en_q <= 1'b0;
            min_q    <= '0;
            max_q    <= '0;
        end else if (wr_en) begin
            case (host_addr)
                PPS_CAP_CTRL: begin
                    enable_q <= host_d4wt[CTRL_ENABLE_BIT];
                    polar_q  <= host_d4wt[CTRL_POLAR_BIT];
                    int_en_q <= host_d4wt[CTRL_INT_EN_BIT];
                end
                PPS_CAP_MIN_PERIOD: min_q <= host_d4wt;
                PPS_CAP_MAX_PERIOD: max_q <= host_d4wt;
                default: ;
            endcase
        end
    end

    assign raw_lvl = sync_q[1] ^ polar_q;

`ifdef PPS_CAP_FILTER_EN
    localparam int unsigned FCW = $clog2(FILTER_LEN + 1);
    localparam logic [FCW-1:0] FILT_LAST = FCW'(FILTER_LEN - 1);

    logic           filt_q;
    logic [FCW-1:0] filt_cnt_q;

    // Level flips only once FILTER_LEN consecutive samples disagree with it.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            filt_q     <= 1'b0;
            filt_cnt_q <= '0;
        end else if (raw_lvl == filt_q) begin
            filt_cnt_q <= '0;
        end else if (filt_cnt_q == FILT_LAST) begin
            filt_q     <= raw_lvl;
            filt_cnt_q <= '0;
        end else begin
            filt_cnt_q <= filt_cnt_q + 1'b1;
        end
    end

    assign lvl = filt_q;
`else
    assign lvl = raw_lvl;
`endif

    assign period   = free_cnt_q - last_cap_q;
    assign in_win   = (period >= min_q) && (period <= max_q);
    assign timeout  = (since_edge_q > max_q);
    assign good_inc = good_cnt_q + 1'b1;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            sync_q        <= '0;
            lvl_prev_q    <= 1'b0;
            edge_q        <= 1'b0;
            free_cnt_q    <= '0;
            last_cap_q    <= '0;
            last_period_q <= '0;
            since_edge_q  <= '0;
            good_cnt_q    <= '0;
            state_q       <= StIdle;
            ovf_q         <= 1'b0;
            missing_q     <= 1'b0;
        end else begin
            sync_q     <= {sync_q[0], pps_in};
            lvl_prev_q <= lvl;
            edge_q     <= lvl & ~lvl_prev_q;
            free_cnt_q <= free_cnt_q + 1'b1;
            if (edge_q) begin
                last_cap_q   <= free_cnt_q;
                since_edge_q <= '0;
            end else if (since_edge_q != '1) begin
                since_edge_q <= since_edge_q + 1'b1;
            end
            if (period_upd) last_period_q <= period;
            good_cnt_q <= good_d;
            state_q    <= state_d;
            // A set in the same cycle as a write-1-to-clear wins.
            ovf_q     <= (ovf_q & ~(status_wr & host_d4wt[STAT_OVF_BIT])) | ovf_set;
            missing_q <= (missing_q & ~(status_wr & host_d4wt[STAT_MISSING_BIT])) | missing_set;
        end
    end

    always_comb begin
        state_d     = state_q;
        good_d      = good_cnt_q;
        missing_set = 1'b0;
        period_upd  = 1'b0;
        unique case (state_q)
            StIdle: if (enable_q) state_d = StAcquire;
            StAcquire: begin
                if (edge_q) begin
                    state_d = StTrack;
                    good_d  = '0;
                end
            end
            StTrack, StLocked: begin
                if (edge_q) begin
                    period_upd = 1'b1;
                    if (!in_win) begin
                        good_d  = '0;
                        state_d = StTrack;
                    end else if (state_q == StTrack) begin
                        good_d = good_inc;
                        if (good_inc == LOCK_TGT) state_d = StLocked;
                    end
                end else if (timeout) begin
                    state_d     = StAcquire;
                    good_d      = '0;
                    missing_set = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
        if (!enable_q) begin
            state_d     = StIdle;
            missing_set = 1'b0;
            period_upd  = 1'b0;
        end
        if (!enable_q || flush) good_d = '0;
    end

    pps_cap_fifo #(
        .FIFO_DEPTH(FIFO_DEPTH),
        .WIDTH     (32)
    ) u_fifo (
        .clk      (clk),
        .rst_b    (rst_b),
        .flush    (flush),
        .push     (push),
        .push_data(free_cnt_q),
        .pop      (pop),
        .rd_data  (fifo_rd_data),
        .count    (fifo_cnt),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign pps_locked  = (state_q == StLocked);
    assign pps_cap_irq = int_en_q & ((fifo_cnt != '0) | missing_q);

    always_comb begin
        host_d4rd = '0;
        case (host_addr)
            PPS_CAP_CTRL:        host_d4rd = {29'd0, int_en_q, polar_q, enable_q};
            PPS_CAP_STATUS:      host_d4rd = {26'd0, ovf_q, missing_q, pps_locked,
                                              sat_cnt3(32'(fifo_cnt))};
            PPS_CAP_MIN_PERIOD:  host_d4rd = min_q;
            PPS_CAP_MAX_PERIOD:  host_d4rd = max_q;
            PPS_CAP_FIFO_DATA:   host_d4rd = fifo_empty ? 32'd0 : fifo_rd_data;
            PPS_CAP_LAST_PERIOD: host_d4rd = last_period_q;
            PPS_CAP_FREE_COUNT:  host_d4rd = free_cnt_q;
            default:             host_d4rd = '0;
        endcase
    end

endmodule

// File: tb/tb_pps_capture.sv
// Scoreboard bench for pps_capture: expected captures are queued at stimulus time and
// checked by a monitor whenever the host pops FIFO_DATA.
`timescale 1ns/1ps
module tb_pps_capture;
    import gnss_pps_pkg::*;

    localparam int unsigned FIFO_DEPTH = 4;
`ifdef PPS_CAP_FILTER_EN
    localparam int unsigned LAT = 7;
`else
    localparam int unsigned LAT = 3;
`endif

    logic        clk = 1'b0;
    logic        rst_b = 1'b0;
    logic        host_cs = 1'b0, host_rd = 1'b0, host_wr = 1'b0;
    logic [5:0]  host_addr = '0;
    logic [31:0] host_d4wt = '0;
    logic [31:0] host_d4rd;
    logic        pps_in = 1'b0;
    logic        pps_cap_irq, pps_locked;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] tb_cyc;
    logic [31:0] exp_q [$];
    bit          sb_bypass = 1'b0;

    always #5 clk = ~clk;

    pps_capture #(
        .FIFO_DEPTH(FIFO_DEPTH),
        .LOCK_CNT  (3),
        .FILTER_LEN(4)
    ) dut (
        .clk        (clk),
        .rst_b      (rst_b),
        .host_cs    (host_cs),
        .host_rd    (host_rd),
        .host_wr    (host_wr),
        .host_addr  (host_addr),
        .host_d4wt  (host_d4wt),
        .host_d4rd  (host_d4rd),
        .pps_in     (pps_in),
        .pps_cap_irq(pps_cap_irq),
        .pps_locked (pps_locked)
    );

    // Cycle reference: equals the expected free-running count after each posedge.
    always @(posedge clk or negedge rst_b) begin
        if (!rst_b) tb_cyc <= '0;
        else        tb_cyc <= tb_cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic sb_push(input logic [31:0] v);
        if (exp_q.size() < FIFO_DEPTH) exp_q.push_back(v);
    endtask

    initial begin : monitor
        logic [31:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (host_cs && host_rd && host_addr == PPS_CAP_FIFO_DATA && !sb_bypass) begin
                e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'd0;
                check("fifo_data", host_d4rd, e);
            end
        end
    end

    task automatic write_reg(input logic [5:0] a, input logic [31:0] d);
        @(negedge clk);
        host_cs = 1'b1; host_wr = 1'b1; host_addr = a; host_d4wt = d;
        @(negedge clk);
        host_cs = 1'b0; host_wr = 1'b0;
    endtask

    task automatic read_fifo();
        @(negedge clk);
        host_cs = 1'b1; host_rd = 1'b1; host_addr = PPS_CAP_FIFO_DATA;
        @(negedge clk);
        host_cs = 1'b0; host_rd = 1'b0;
    endtask

    task automatic read_raw(output logic [31:0] d);
        @(negedge clk);
        host_cs = 1'b1; host_rd = 1'b1; host_addr = PPS_CAP_FIFO_DATA;
        #1 d = host_d4rd;
        @(negedge clk);
        host_cs = 1'b0; host_rd = 1'b0;
    endtask

    task automatic peek(input logic [5:0] a, output logic [31:0] d);
        host_addr = a;
        #1 d = host_d4rd;
    endtask

    // Rising edges exactly 'period' cycles apart; each occupies a 30-cycle block with an
    // optional FIFO read 20 cycles after the rise.
    task automatic pulse_train(input int n, input int period, input int first_wait,
                               input bit do_read, input bit push_exp);
        for (int i = 0; i < n; i++) begin
            repeat ((i == 0) ? first_wait : period - 30) @(negedge clk);
            for (int j = 0; j < 30; j++) begin
                @(negedge clk);
                if (j == 0) begin
                    pps_in = 1'b1;
                    if (push_exp) sb_push(tb_cyc + LAT);
                end
                if (j == 10) pps_in = 1'b0;
                if (j == 20 && do_read) begin
                    host_cs = 1'b1; host_rd = 1'b1; host_addr = PPS_CAP_FIFO_DATA;
                end
                if (j == 21) begin
                    host_cs = 1'b0; host_rd = 1'b0;
                end
            end
        end
    endtask

    initial begin : stim
        logic [31:0] d, cap1, cap2;
        repeat (3) @(negedge clk);
        rst_b = 1'b1;
        @(negedge clk);

        check("rst_locked", {31'd0, pps_locked}, 32'd0);
        check("rst_irq", {31'd0, pps_cap_irq}, 32'd0);
        peek(PPS_CAP_CTRL, d);        check("rst_ctrl", d, 32'd0);
        peek(PPS_CAP_STATUS, d);      check("rst_status", d, 32'd0);
        peek(PPS_CAP_LAST_PERIOD, d); check("rst_last_period", d, 32'd0);
        peek(6'd9, d);                check("rst_unmapped", d, 32'd0);
        read_fifo();

        write_reg(PPS_CAP_MIN_PERIOD, 32'd990);
        write_reg(PPS_CAP_MAX_PERIOD, 32'd1010);
        write_reg(PPS_CAP_CTRL, 32'h5);
        peek(PPS_CAP_MAX_PERIOD, d);  check("max_period", d, 32'd1010);

        // Lock acquisition on the 4th edge.
        pulse_train(3, 1000, 2, 1'b1, 1'b1);
        check("locked_after_3", {31'd0, pps_locked}, 32'd0);
        pulse_train(1, 1000, 970, 1'b1, 1'b1);
        check("locked_after_4", {31'd0, pps_locked}, 32'd1);
        peek(PPS_CAP_LAST_PERIOD, d); check("last_period", d, 32'd1000);
        peek(PPS_CAP_STATUS, d);      check("status_locked", {31'd0, d[STAT_LOCKED_BIT]}, 32'd1);

        // One 1200-cycle gap drops lock; three good periods relock.
        pulse_train(1, 1200, 1170, 1'b1, 1'b1);
        check("unlock_1200", {31'd0, pps_locked}, 32'd0);
        check("state_track", 32'(dut.state_q), 32'(StTrack));
        peek(PPS_CAP_STATUS, d);      check("missing_on_gap", {31'd0, d[STAT_MISSING_BIT]}, 32'd1);
        write_reg(PPS_CAP_STATUS, 32'h10);
        pulse_train(2, 1000, 968, 1'b1, 1'b1);
        check("relock_after_2", {31'd0, pps_locked}, 32'd0);
        pulse_train(1, 1000, 970, 1'b1, 1'b1);
        check("relock_after_3", {31'd0, pps_locked}, 32'd1);

        // Loss of signal.
        repeat (976) @(negedge clk);
        peek(PPS_CAP_STATUS, d);      check("no_missing_1005", {31'd0, d[STAT_MISSING_BIT]}, 32'd0);
        check("still_locked_1005", {31'd0, pps_locked}, 32'd1);
        repeat (25) @(negedge clk);
        peek(PPS_CAP_STATUS, d);      check("missing_1030", {31'd0, d[STAT_MISSING_BIT]}, 32'd1);
        check("state_acquire", 32'(dut.state_q), 32'(StAcquire));
        check("irq_missing", {31'd0, pps_cap_irq}, 32'd1);
        write_reg(PPS_CAP_STATUS, 32'h10);
        peek(PPS_CAP_STATUS, d);      check("missing_cleared", {31'd0, d[STAT_MISSING_BIT]}, 32'd0);
        check("irq_cleared", {31'd0, pps_cap_irq}, 32'd0);

        // Overflow: six edges, no reads.
        write_reg(PPS_CAP_CTRL, 32'h4);
        write_reg(PPS_CAP_CTRL, 32'h5);
        exp_q.delete();
        pulse_train(6, 1000, 2, 1'b0, 1'b1);
        peek(PPS_CAP_STATUS, d);
        check("ovf_fifo_cnt", {29'd0, d[2:0]}, 32'd4);
        check("ovf_set", {31'd0, d[STAT_OVF_BIT]}, 32'd1);
        check("irq_fifo", {31'd0, pps_cap_irq}, 32'd1);
        repeat (5) read_fifo();
        peek(PPS_CAP_STATUS, d);      check("drained_cnt", {29'd0, d[2:0]}, 32'd0);
        write_reg(PPS_CAP_STATUS, 32'h20);
        peek(PPS_CAP_STATUS, d);      check("ovf_cleared", {31'd0, d[STAT_OVF_BIT]}, 32'd0);

        // Short pulses.
        write_reg(PPS_CAP_CTRL, 32'h4);
        write_reg(PPS_CAP_CTRL, 32'h5);
`ifdef PPS_CAP_FILTER_EN
        @(negedge clk); pps_in = 1'b1;
        repeat (3) @(negedge clk); pps_in = 1'b0;
        repeat (20) @(negedge clk);
        peek(PPS_CAP_STATUS, d);      check("glitch_rejected", {29'd0, d[2:0]}, 32'd0);
`endif
        @(negedge clk); pps_in = 1'b1; sb_push(tb_cyc + LAT);
        repeat (4) @(negedge clk); pps_in = 1'b0;
        repeat (20) @(negedge clk);
        read_fifo();

        // Inverted polarity: capture on falling edges only.
        write_reg(PPS_CAP_CTRL, 32'h4);
        pps_in = 1'b1;
        write_reg(PPS_CAP_CTRL, 32'h6);
        repeat (20) @(negedge clk);
        write_reg(PPS_CAP_CTRL, 32'h7);
        repeat (5) @(negedge clk);
        pps_in = 1'b0; sb_push(tb_cyc + LAT);
        repeat (20) @(negedge clk);
        read_fifo();
        pps_in = 1'b1;
        repeat (20) @(negedge clk);
        peek(PPS_CAP_STATUS, d);      check("polar_rise_ignored", {29'd0, d[2:0]}, 32'd0);
        write_reg(PPS_CAP_CTRL, 32'h4);
        pps_in = 1'b0;
        repeat (10) @(negedge clk);

        // Counter wrap between two captures.
        write_reg(PPS_CAP_CTRL, 32'h5);
        @(negedge clk);
        force dut.free_cnt_q = 32'hFFFF_FEF0;
        @(negedge clk);
        release dut.free_cnt_q;
        pulse_train(2, 1000, 0, 1'b0, 1'b0);
        sb_bypass = 1'b1;
        read_raw(cap1);
        read_raw(cap2);
        sb_bypass = 1'b0;
        check("wrap_delta", cap2 - cap1, 32'd1000);
        check("wrap_cap1_top", {12'd0, cap1[31:12]}, 32'h000F_FFFF);
        check("wrap_cap2_low", {12'd0, cap2[31:12]}, 32'd0);
        peek(PPS_CAP_LAST_PERIOD, d); check("wrap_period", d, 32'd1000);
        check("wrap_good_cnt", 32'(dut.good_cnt_q), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
